// File: rtl/serdesphy_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serdesphy_tx_pkg
// Description : Shared types and constants for the TX differential driver.
// Revision    : 1.0 - initial release
// ============================================================================
package serdesphy_tx_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_BIAS   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } tx_state_e;

    localparam int              c_SWING_W   = 4;
    localparam logic [3:0]      c_SWING_MSB = 4'b1000;
    localparam int              c_RUN_W     = 4;
    localparam logic [3:0]      c_RUN_SAT   = 4'd15;
    localparam int              c_BIAS_W    = 8;

    // Main-cursor amplitude, optionally reduced by the de-emphasis step
    // and floored at zero.
    function automatic logic [c_SWING_W-1:0] f_swing(
        input logic [2:0] code,
        input logic       apply,
        input int         step
    );
        int v;
        v = int'(c_SWING_MSB | {1'b0, code});
        if (apply) begin
            v = v - step;
            if (v < 0) begin
                v = 0;
            end
        end
        return c_SWING_W'(v);
    endfunction

endpackage : serdesphy_tx_pkg
`default_nettype wire

// File: rtl/serdesphy_tx_deemph_runlen.sv
`default_nettype none
// ============================================================================
// Module      : serdesphy_tx_deemph_runlen
// Description : Per-bit de-emphasis swing code and sticky run-length check.
// Revision    : 1.0 - initial release
// ============================================================================
module serdesphy_tx_deemph_runlen
    import serdesphy_tx_pkg::*;
#(
    parameter int DEEMPH_STEP = 3,
    parameter int MAX_RUN     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 active,
    input  logic                 clear,
    input  logic                 kill,
    input  logic                 deemph_en,
    input  logic [2:0]           swing_code,
    output logic [c_SWING_W-1:0] tx_swing,
    output logic                 run_err
);

    localparam logic [c_RUN_W-1:0] c_MAX_RUN = c_RUN_W'(MAX_RUN);

    logic                 r_prev_bit;
    logic                 r_first;
    logic [c_RUN_W-1:0]   r_run_cnt;
    logic [c_SWING_W-1:0] r_tx_swing;
    logic                 r_run_err;

    logic                 w_repeat;
    logic [c_RUN_W-1:0]   w_run_next;
    logic [c_SWING_W-1:0] w_swing;

    always_comb begin
        w_repeat   = ~r_first & (bit_in == r_prev_bit);
        w_run_next = 4'd1;
        if (w_repeat) begin
            w_run_next = (r_run_cnt == c_RUN_SAT) ? r_run_cnt : r_run_cnt + 4'd1;
        end
        w_swing = f_swing(swing_code, deemph_en & w_repeat, DEEMPH_STEP);
    end

    // kill covers both OFF and the override edge; run_err only clears there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_bit <= 1'b0;
            r_first    <= 1'b0;
            r_run_cnt  <= '0;
            r_tx_swing <= '0;
            r_run_err  <= 1'b0;
        end else if (kill) begin
            r_prev_bit <= 1'b0;
            r_first    <= 1'b0;
            r_run_cnt  <= '0;
            r_tx_swing <= '0;
            r_run_err  <= 1'b0;
        end else if (clear) begin
            r_first    <= 1'b1;
            r_run_cnt  <= '0;
            r_tx_swing <= '0;
        end else if (active) begin
            r_prev_bit <= bit_in;
            r_first    <= 1'b0;
            r_run_cnt  <= w_run_next;
            r_tx_swing <= w_swing;
            if (w_run_next > c_MAX_RUN) begin
                r_run_err <= 1'b1;
            end
        end else begin
            r_tx_swing <= '0;
        end
    end

    assign tx_swing = r_tx_swing;
    assign run_err  = r_run_err;

endmodule : serdesphy_tx_deemph_runlen
`default_nettype wire

// File: rtl/serdesphy_ana_tx_differential_driver.sv
`default_nettype none
// ============================================================================
// Module      : serdesphy_ana_tx_differential_driver
// Description : TX line driver model: bias sequencing, electrical idle,
//               differential pad drive, near-end loopback and de-emphasis.
// Revision    : 1.0 - initial release
// ============================================================================
module serdesphy_ana_tx_differential_driver
    import serdesphy_tx_pkg::*;
#(
    parameter int BIAS_CYCLES = 16,
    parameter int DEEMPH_STEP = 3,
    parameter int MAX_RUN     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 iso_en,
    input  logic                 lpbk_en,
    input  logic                 elec_idle,
    input  logic                 deemph_en,
    input  logic [2:0]           swing_code,
    input  logic                 serial_data,
    output logic                 txp,
    output logic                 txn,
    output logic [c_SWING_W-1:0] tx_swing,
    output logic                 lpbk_data,
    output logic                 driver_ready,
    output logic                 run_err
);

    localparam logic [c_BIAS_W-1:0] c_BIAS_LOAD = c_BIAS_W'(BIAS_CYCLES - 1);

    tx_state_e           r_state;
    tx_state_e           w_state_next;
    logic [c_BIAS_W-1:0] r_bias_cnt;
    logic [c_BIAS_W-1:0] w_bias_next;

    logic                w_override;
    logic                w_active;
    logic                w_clear;
    logic                w_kill;

    logic                r_txp;
    logic                r_txn;
    logic                r_lpbk_data;
    logic                r_driver_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_OFF;
            r_bias_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_bias_cnt <= w_bias_next;
        end
    end

    // Priority: isolation/disable, then electrical idle, then data.
    always_comb begin
        w_state_next = r_state;
        w_bias_next  = r_bias_cnt;
        w_override   = ~enable | iso_en;
        w_active     = 1'b0;
        w_clear      = 1'b0;
        if (w_override) begin
            w_state_next = ST_OFF;
            w_bias_next  = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_next = ST_BIAS;
                    w_bias_next  = c_BIAS_LOAD;
                end
                ST_BIAS: begin
                    if (r_bias_cnt == '0) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_bias_next = r_bias_cnt - 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (!elec_idle) begin
                        w_state_next = ST_ACTIVE;
                        w_clear      = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (elec_idle) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_active = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_OFF;
                    w_bias_next  = '0;
                end
            endcase
        end
        w_kill = w_override | (r_state == ST_OFF);
    end

    // Pads and loopback are mutually exclusive; both idle low outside ACTIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txp          <= 1'b0;
            r_txn          <= 1'b0;
            r_lpbk_data    <= 1'b0;
            r_driver_ready <= 1'b0;
        end else begin
            r_txp          <= w_active & ~lpbk_en &  serial_data;
            r_txn          <= w_active & ~lpbk_en & ~serial_data;
            r_lpbk_data    <= w_active &  lpbk_en &  serial_data;
            r_driver_ready <= (w_state_next == ST_IDLE) | (w_state_next == ST_ACTIVE);
        end
    end

    serdesphy_tx_deemph_runlen #(
        .DEEMPH_STEP (DEEMPH_STEP),
        .MAX_RUN     (MAX_RUN)
    ) u_deemph_runlen (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (serial_data),
        .active     (w_active),
        .clear      (w_clear),
        .kill       (w_kill),
        .deemph_en  (deemph_en),
        .swing_code (swing_code),
        .tx_swing   (tx_swing),
        .run_err    (run_err)
    );

    assign txp          = r_txp;
    assign txn          = r_txn;
    assign lpbk_data    = r_lpbk_data;
    assign driver_ready = r_driver_ready;

endmodule : serdesphy_ana_tx_differential_driver
`default_nettype wire

// File: tb/tb_serdesphy_ana_tx_differential_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serdesphy_ana_tx_differential_driver
// Description : Directed plus randomized bench with a bit-history reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serdesphy_ana_tx_differential_driver;

    localparam int BIAS_CYCLES = 16;
    localparam int DEEMPH_STEP = 3;
    localparam int MAX_RUN     = 5;

    localparam int P_OFF = 0, P_BIAS = 1, P_IDLE = 2, P_ACTIVE = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, iso_en, lpbk_en, elec_idle, deemph_en, serial_data;
    logic [2:0] swing_code;
    logic       txp, txn, lpbk_data, driver_ready, run_err;
    logic [3:0] tx_swing;

    always #5 clk = ~clk;

    serdesphy_ana_tx_differential_driver #(
        .BIAS_CYCLES (BIAS_CYCLES),
        .DEEMPH_STEP (DEEMPH_STEP),
        .MAX_RUN     (MAX_RUN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .iso_en       (iso_en),
        .lpbk_en      (lpbk_en),
        .elec_idle    (elec_idle),
        .deemph_en    (deemph_en),
        .swing_code   (swing_code),
        .serial_data  (serial_data),
        .txp          (txp),
        .txn          (txn),
        .tx_swing     (tx_swing),
        .lpbk_data    (lpbk_data),
        .driver_ready (driver_ready),
        .run_err      (run_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: phase plus elapsed-edge count and the history of bits sent
    // since the current ACTIVE entry.
    int   m_phase;
    int   m_elapsed;
    bit   m_hist[$];
    bit   m_err;
    logic e_txp, e_txn, e_lpbk, e_ready;
    logic [3:0] e_swing;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit ovr, rep;
        int full, run;
        ovr = !enable || iso_en;
        e_txp = 0; e_txn = 0; e_lpbk = 0; e_ready = 0; e_swing = 0;
        if (ovr) begin
            m_phase = P_OFF;
            m_err   = 0;
            m_hist.delete();
        end else begin
            case (m_phase)
                P_OFF: begin
                    m_phase   = P_BIAS;
                    m_elapsed = 1;
                end
                P_BIAS: begin
                    m_elapsed++;
                    if (m_elapsed == BIAS_CYCLES + 1) begin
                        m_phase = P_IDLE;
                        e_ready = 1;
                    end
                end
                P_IDLE: begin
                    e_ready = 1;
                    if (!elec_idle) begin
                        m_phase = P_ACTIVE;
                        m_hist.delete();
                    end
                end
                default: begin
                    e_ready = 1;
                    if (elec_idle) begin
                        m_phase = P_IDLE;
                    end else begin
                        rep  = (m_hist.size() > 0) && (m_hist[$] == serial_data);
                        full = 8 + int'(swing_code);
                        if (deemph_en && rep)
                            e_swing = 4'((full > DEEMPH_STEP) ? full - DEEMPH_STEP : 0);
                        else
                            e_swing = 4'(full);
                        m_hist.push_back(serial_data);
                        if (m_hist.size() > 20) void'(m_hist.pop_front());
                        run = 0;
                        for (int i = m_hist.size() - 1; i >= 0; i--) begin
                            if (m_hist[i] != serial_data) break;
                            run++;
                        end
                        if (run > 15) run = 15;
                        if (run > MAX_RUN) m_err = 1;
                        if (lpbk_en) e_lpbk = serial_data;
                        else begin
                            e_txp = serial_data;
                            e_txn = !serial_data;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".txp"},   {7'd0, txp},          {7'd0, e_txp});
        chk({tag, ".txn"},   {7'd0, txn},          {7'd0, e_txn});
        chk({tag, ".swing"}, {4'd0, tx_swing},     {4'd0, e_swing});
        chk({tag, ".lpbk"},  {7'd0, lpbk_data},    {7'd0, e_lpbk});
        chk({tag, ".ready"}, {7'd0, driver_ready}, {7'd0, e_ready});
        chk({tag, ".err"},   {7'd0, run_err},      {7'd0, m_err});
    endtask

    initial begin : stim
        logic [3:0] exp_sw[4];
        logic       pat[6];

        rst_n = 0; enable = 1; iso_en = 0; lpbk_en = 0; elec_idle = 1;
        deemph_en = 1; swing_code = 3'd5; serial_data = 0;
        m_phase = P_OFF; m_elapsed = 0; m_err = 0;
        repeat (2) @(negedge clk);
        chk("reset.all", {txp, txn, tx_swing, lpbk_data, driver_ready}, 8'd0);
        chk("reset.err", {7'd0, run_err}, 8'd0);
        rst_n = 1;

        // Bias settling: ready only on the 17th edge after enable is seen.
        for (int k = 1; k <= 17; k++) begin
            step("bias");
            chk("t1.ready", {7'd0, driver_ready}, (k == 17) ? 8'd1 : 8'd0);
        end

        // Enter ACTIVE, pattern 1,0,1,1 with swing_code 5.
        elec_idle = 0;
        step("t2.entry");
        exp_sw = '{4'd13, 4'd13, 4'd13, 4'd10};
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1;
        for (int k = 0; k < 4; k++) begin
            serial_data = pat[k];
            step("t2");
            chk("t2.swing", {4'd0, tx_swing}, {4'd0, exp_sw[k]});
            chk("t2.txp", {6'd0, txp, txn}, {6'd0, pat[k], ~pat[k]});
        end

        // Run-length: re-entry restarts the count, six 1s then violate.
        elec_idle = 1; step("t3.idle");
        elec_idle = 0; step("t3.entry");
        serial_data = 1;
        for (int k = 1; k <= 6; k++) begin
            step("t3.run");
            chk("t3.run_err", {7'd0, run_err}, (k == 6) ? 8'd1 : 8'd0);
        end
        elec_idle = 1; step("t3.idle2");
        elec_idle = 0; step("t3.entry2");
        chk("t3.sticky", {7'd0, run_err}, 8'd1);
        enable = 0; step("t3.off");
        chk("t3.cleared", {7'd0, run_err}, 8'd0);

        // Isolation mid-BIAS abandons the count.
        enable = 1; elec_idle = 1;
        for (int k = 0; k < 8; k++) step("t5.bias");
        iso_en = 1; step("t5.iso");
        chk("t5.off", {txp, txn, tx_swing, lpbk_data, driver_ready}, 8'd0);
        iso_en = 0;
        for (int k = 1; k <= 17; k++) begin
            step("t5.rebias");
            chk("t5.ready", {7'd0, driver_ready}, (k == 17) ? 8'd1 : 8'd0);
        end

        // Near-end loopback.
        elec_idle = 0; step("t4.entry");
        lpbk_en = 1;
        pat[0] = 0; pat[1] = 1; pat[2] = 1; pat[3] = 0;
        for (int k = 0; k < 4; k++) begin
            serial_data = pat[k];
            step("t4");
            chk("t4.lpbk", {5'd0, txp, txn, lpbk_data}, {7'd0, pat[k]});
        end
        lpbk_en = 0;

        // Minimum swing with alternating pairs, then override beats elec_idle.
        elec_idle = 1; step("t6.idle");
        elec_idle = 0; step("t6.entry");
        swing_code = 3'd0;
        pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            serial_data = pat[k];
            step("t6");
            chk("t6.swing", {4'd0, tx_swing}, (k % 2 == 0) ? 8'd8 : 8'd5);
        end
        elec_idle = 1; enable = 0; step("t6.override");
        chk("t6.off", {txp, txn, tx_swing, lpbk_data, driver_ready}, 8'd0);

        // Randomized traffic with occasional idle, loopback and override.
        enable = 1;
        for (int k = 0; k < 1500; k++) begin
            serial_data = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) serial_data = pat[0];
            pat[0]      = serial_data;
            elec_idle   = ($urandom_range(0, 15) == 0);
            lpbk_en     = ($urandom_range(0, 5) == 0);
            deemph_en   = ($urandom_range(0, 4) != 0);
            swing_code  = 3'($urandom_range(0, 7));
            enable      = ($urandom_range(0, 299) != 0);
            iso_en      = ($urandom_range(0, 399) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serdesphy_ana_tx_differential_driver
`default_nettype wire
